// File: rtl/layer_cfg_sequencer.sv
// Layer-descriptor table plus sequencer: host fills one descriptor per layer, then the block
// walks entries 0..num_layers-1, presenting each with derived output dims and waiting for layer_done.
module layer_cfg_sequencer #(
  parameter int unsigned MAX_LAYERS = 32,
  parameter int unsigned ID_W       = 5,
  parameter int unsigned WB_W       = 20,
  parameter int unsigned BB_W       = 12,
  parameter int unsigned CH_W       = 11,
  parameter int unsigned DIM_W      = 8,
  localparam int unsigned ENT_W     = WB_W + BB_W + 3 + 2*CH_W + 2*DIM_W + 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [ID_W-1:0]    cfg_waddr,
  input  logic [ENT_W-1:0]   cfg_wdata,
  input  logic               start,
  input  logic [ID_W:0]      num_layers,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ID_W-1:0]    out_id,
  output logic [ENT_W-1:0]   out_desc,
  output logic [DIM_W-1:0]   out_ow,
  output logic [DIM_W-1:0]   out_oh,
  input  logic               layer_done,
  output logic               busy,
  output logic               all_done,
  output logic               err
);

  // Field positions inside a descriptor (LSB side: stride, img_h, img_w)
  localparam int unsigned STR_LO = 0;
  localparam int unsigned IH_LO  = 2;
  localparam int unsigned IW_LO  = IH_LO + DIM_W;
  localparam int unsigned CNT_W  = ID_W + 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_PRESENT = 3'd2,
    S_RUN     = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [ENT_W-1:0]   r_ram [MAX_LAYERS];
  logic [ENT_W-1:0]   r_desc;
  logic [ID_W-1:0]    r_id;
  logic [CNT_W-1:0]   r_num;
  logic               r_err;

  logic               w_num_ok;
  logic               w_waddr_ok;
  logic               w_wr_ok;
  logic               w_stride_ok;
  logic               w_last;
  logic               w_err_c;
  logic [1:0]         w_stride;
  logic [DIM_W-1:0]   w_img_w;
  logic [DIM_W-1:0]   w_img_h;

  assign w_stride    = r_desc[STR_LO +: 2];
  assign w_img_w     = r_desc[IW_LO +: DIM_W];
  assign w_img_h     = r_desc[IH_LO +: DIM_W];
  assign w_stride_ok = (w_stride == 2'd1) || (w_stride == 2'd2);
  assign w_num_ok    = (num_layers != '0) && (num_layers <= CNT_W'(MAX_LAYERS));
  assign w_waddr_ok  = {1'b0, cfg_waddr} < CNT_W'(MAX_LAYERS);
  assign w_wr_ok     = cfg_we && (r_state == S_IDLE) && w_waddr_ok;
  assign w_last      = ({1'b0, r_id} + CNT_W'(1)) == r_num;

  // Every rejected event: late/out-of-range write, illegal start, illegal stride
  assign w_err_c = (cfg_we && ((r_state != S_IDLE) || !w_waddr_ok))
                 || ((r_state == S_IDLE) && start && !w_num_ok)
                 || ((r_state == S_PRESENT) && !w_stride_ok);

  // Table storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_ram[cfg_waddr] <= cfg_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start && w_num_ok) w_next = S_FETCH;
      S_FETCH:   w_next = S_PRESENT;
      S_PRESENT: begin
        if (!w_stride_ok)   w_next = S_IDLE;
        else if (out_ready) w_next = S_RUN;
      end
      S_RUN:     if (layer_done) w_next = w_last ? S_DONE : S_FETCH;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Sequence bookkeeping and registered table read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id   <= '0;
      r_num  <= '0;
      r_desc <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_err_c;
      if ((r_state == S_IDLE) && start && w_num_ok) begin
        r_id  <= '0;
        r_num <= num_layers;
      end else if ((r_state == S_RUN) && layer_done) begin
        r_id <= r_id + ID_W'(1);
      end
      if (r_state == S_FETCH) begin
        r_desc <= r_ram[r_id];
      end
    end
  end

  always_comb begin
    out_valid = (r_state == S_PRESENT) && w_stride_ok;
    busy      = (r_state != S_IDLE);
    all_done  = (r_state == S_DONE);
    err       = r_err;
    out_id    = r_id;
    out_desc  = r_desc;
    out_ow    = w_img_w;
    out_oh    = w_img_h;
    if (w_stride == 2'd2) begin
      out_ow = DIM_W'(({1'b0, w_img_w} + (DIM_W+1)'(1)) >> 1);
      out_oh = DIM_W'(({1'b0, w_img_h} + (DIM_W+1)'(1)) >> 1);
    end
  end

endmodule

// File: tb/tb_layer_cfg_sequencer.sv
// Directed bench for layer_cfg_sequencer: a table/sequence model sets per-cycle expectations,
// one negedge process compares every output, and literal checks pin the derived dims.
module tb_layer_cfg_sequencer;

  localparam int unsigned ENT_W = 75;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_we = 1'b0;
  logic [4:0]       cfg_waddr = '0;
  logic [ENT_W-1:0] cfg_wdata = '0;
  logic             start = 1'b0;
  logic [5:0]       num_layers = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [4:0]       out_id;
  logic [ENT_W-1:0] out_desc;
  logic [7:0]       out_ow;
  logic [7:0]       out_oh;
  logic             layer_done = 1'b0;
  logic             busy;
  logic             all_done;
  logic             err;

  layer_cfg_sequencer dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_waddr(cfg_waddr), .cfg_wdata(cfg_wdata),
    .start(start), .num_layers(num_layers), .out_valid(out_valid), .out_ready(out_ready),
    .out_id(out_id), .out_desc(out_desc), .out_ow(out_ow), .out_oh(out_oh),
    .layer_done(layer_done), .busy(busy), .all_done(all_done), .err(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: table contents and what each output must be this cycle
  logic [ENT_W-1:0] m_tab [32];
  logic             m_busy = 1'b0;
  logic             m_valid = 1'b0;
  logic             m_done = 1'b0;
  logic             m_err = 1'b0;
  logic [4:0]       m_id = '0;
  bit               chk_en = 1'b0;

  logic [7:0]       obs_ow [8];
  logic [7:0]       obs_oh [8];
  logic [4:0]       obs_id [8];
  logic [ENT_W-1:0] obs_desc [8];

  task automatic chk(input string name, input logic [ENT_W-1:0] act, input logic [ENT_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [ENT_W-1:0] mk(input int wb, input int bb, input int lt, input int cin,
                                          input int cout, input int w, input int h, input int s);
    logic [19:0] f_wb = 20'(wb);
    logic [11:0] f_bb = 12'(bb);
    logic [2:0]  f_lt = 3'(lt);
    logic [10:0] f_ci = 11'(cin);
    logic [10:0] f_co = 11'(cout);
    logic [7:0]  f_w  = 8'(w);
    logic [7:0]  f_h  = 8'(h);
    logic [1:0]  f_s  = 2'(s);
    return {f_wb, f_bb, f_lt, f_ci, f_co, f_w, f_h, f_s};
  endfunction

  function automatic int fld_s(input logic [ENT_W-1:0] d);
    return int'(d[1:0]);
  endfunction

  // Output dimension rule: unchanged for stride 1, ceil(x/2) for stride 2
  function automatic logic [7:0] dim(input logic [7:0] v, input int s);
    if (s == 2) return 8'((int'(v) + 1) / 2);
    return v;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", ENT_W'(busy), ENT_W'(m_busy));
      chk("out_valid", ENT_W'(out_valid), ENT_W'(m_valid));
      chk("all_done", ENT_W'(all_done), ENT_W'(m_done));
      chk("err", ENT_W'(err), ENT_W'(m_err));
      if (m_valid) begin
        chk("out_id", ENT_W'(out_id), ENT_W'(m_id));
        chk("out_desc", out_desc, m_tab[m_id]);
        chk("out_ow", ENT_W'(out_ow), ENT_W'(dim(m_tab[m_id][17:10], fld_s(m_tab[m_id]))));
        chk("out_oh", ENT_W'(out_oh), ENT_W'(dim(m_tab[m_id][9:2], fld_s(m_tab[m_id]))));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    m_err  = 1'b0;
    m_done = 1'b0;
  endtask

  task automatic cfg_write(input int a, input logic [ENT_W-1:0] d, input bit ok);
    cfg_we = 1'b1; cfg_waddr = 5'(a); cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
    if (ok) m_tab[a] = d;
    else    m_err = 1'b1;
  endtask

  task automatic start_reject(input int n);
    start = 1'b1; num_layers = 6'(n);
    tick();
    start = 1'b0;
    m_err = 1'b1;
    tick();
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_valid"}, ENT_W'(out_valid), '0);
    chk({tag, "_id"},    ENT_W'(out_id), '0);
    chk({tag, "_desc"},  out_desc, '0);
    chk({tag, "_ow"},    ENT_W'(out_ow), '0);
    chk({tag, "_oh"},    ENT_W'(out_oh), '0);
    chk({tag, "_busy"},  ENT_W'(busy), '0);
    chk({tag, "_done"},  ENT_W'(all_done), '0);
    chk({tag, "_err"},   ENT_W'(err), '0);
  endtask

  // Runs one sequence; optional early layer_done, rejected write in RUN, or reset in RUN of a layer
  task automatic run_seq(input int n, input int rdy_wait, input int done_wait,
                         input bit ld_early, input bit we_in_run, input int rst_layer);
    start = 1'b1; num_layers = 6'(n);
    tick();
    start = 1'b0;
    m_busy = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      m_id = 5'(i);
      if (fld_s(m_tab[i]) != 1 && fld_s(m_tab[i]) != 2) begin
        m_valid = 1'b0;
        tick();
        m_busy = 1'b0;
        m_err  = 1'b1;
        tick();
        return;
      end
      m_valid = 1'b1;
      for (int k = 0; k < rdy_wait; k++) begin
        layer_done = ld_early && (k == 0);
        tick();
      end
      layer_done = 1'b0;
      out_ready  = 1'b1;
      obs_id[i] = out_id; obs_ow[i] = out_ow; obs_oh[i] = out_oh; obs_desc[i] = out_desc;
      tick();
      out_ready = 1'b0;
      m_valid   = 1'b0;
      if (i == rst_layer) begin
        #2 rst_n = 1'b0;
        #1 all_zero("async_rst");
        m_busy = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        return;
      end
      for (int k = 0; k < done_wait; k++) begin
        if (we_in_run && k == 0) cfg_write(0, mk(5, 5, 5, 5, 5, 5, 5, 1), 1'b0);
        else                     tick();
      end
      layer_done = 1'b1;
      tick();
      layer_done = 1'b0;
      if (i == n - 1) begin
        m_done = 1'b1;
        tick();
        m_busy = 1'b0;
      end
    end
    tick();
  endtask

  logic [ENT_W-1:0] d_conv, d_dw, d_pw, d_e7, d_bad;

  initial begin
    d_conv = mk(32'h00100, 12'h010, 0, 3, 32, 224, 224, 2);
    d_dw   = mk(32'h00400, 12'h020, 1, 32, 32, 112, 112, 1);
    d_pw   = mk(32'h00800, 12'h030, 2, 32, 64, 112, 112, 1);
    d_e7   = mk(32'h00900, 12'h040, 3, 16, 16, 7, 9, 2);
    d_bad  = mk(32'h00a00, 12'h050, 4, 8, 8, 20, 20, 0);
    chk_en = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    all_zero("reset");

    // Three-layer MobileNet head
    cfg_write(0, d_conv, 1'b1);
    cfg_write(1, d_dw, 1'b1);
    cfg_write(2, d_pw, 1'b1);
    run_seq(3, 0, 2, 1'b0, 1'b0, -1);
    for (int i = 0; i < 3; i++) begin
      chk("t1_id", ENT_W'(obs_id[i]), ENT_W'(i));
      chk("t1_ow", ENT_W'(obs_ow[i]), ENT_W'(112));
      chk("t1_oh", ENT_W'(obs_oh[i]), ENT_W'(112));
    end

    // Back-pressure, then layer_done while presenting
    run_seq(1, 5, 1, 1'b0, 1'b0, -1);
    run_seq(2, 3, 2, 1'b1, 1'b0, -1);

    // Illegal starts, then a write rejected while running and a readback
    start_reject(0);
    start_reject(33);
    run_seq(1, 0, 3, 1'b0, 1'b1, -1);
    run_seq(1, 0, 0, 1'b0, 1'b0, -1);
    chk("t4_readback", obs_desc[0], d_conv);

    // Odd width with stride 2, then stride 0 aborts
    cfg_write(0, d_e7, 1'b1);
    cfg_write(1, d_bad, 1'b1);
    run_seq(2, 0, 1, 1'b0, 1'b0, -1);
    chk("t3_ow", ENT_W'(obs_ow[0]), ENT_W'(4));
    chk("t3_oh", ENT_W'(obs_oh[0]), ENT_W'(5));

    // Reset in RUN of layer 1, then a clean replay from layer 0
    cfg_write(0, d_conv, 1'b1);
    cfg_write(1, d_dw, 1'b1);
    run_seq(3, 0, 1, 1'b0, 1'b0, 1);
    for (int i = 0; i < 3; i++) obs_id[i] = 5'h1f;
    run_seq(3, 0, 0, 1'b0, 1'b0, -1);
    for (int i = 0; i < 3; i++) begin
      chk("t6_id", ENT_W'(obs_id[i]), ENT_W'(i));
      chk("t6_ow", ENT_W'(obs_ow[i]), ENT_W'(112));
    end
    chk("t6_desc2", obs_desc[2], d_pw);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

endmodule
